bypass_rf_multi: RTL

- Parametrised successor to the single-slot bypass register file used by PDL-generated pipelines.
- Each of the two read ports holds a circular queue of 2**rd_name_width outstanding read reservations instead of one slot, so several in-flight reads per port can wait on bypass data.
- Write-side renaming queue, two write-data ports and in-order write freeing keep their existing semantics.
- Sits between pipeline stages and the architectural register state.

---
 rtl/bypass_rf_multi.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/bypass_rf_multi.sv
// Bypass register file: renaming write queue plus, per read port, a circular
// queue of read reservations that collect bypassed write data while pending.
module bypass_rf_multi #(
    parameter int    addr_width    = 1,
    parameter int    data_width    = 1,
    parameter int    name_width    = 1,
    parameter int    rd_name_width = 1,
    parameter int    lo_arch       = 0,
    parameter int    hi_arch       = 1,
    parameter int    binaryInit    = 0,
    parameter string file          = ""
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [addr_width-1:0]    ADDR_IN,
    input  logic                     ALLOC_E,
    output logic                     ALLOC_READY,
    output logic [name_width-1:0]    NAME_OUT,
    input  logic [addr_width-1:0]    ADDR_1,
    input  logic                     RRESE_1,
    output logic                     RRES_READY_1,
    output logic [rd_name_width-1:0] RNAME_OUT_1,
    input  logic [addr_width-1:0]    ADDR_2,
    input  logic                     RRESE_2,
    output logic                     RRES_READY_2,
    output logic [rd_name_width-1:0] RNAME_OUT_2,
    input  logic [name_width-1:0]    NAME_IN_1,
    input  logic [data_width-1:0]    D_IN_1,
    input  logic                     WE_1,
    input  logic [name_width-1:0]    NAME_IN_2,
    input  logic [data_width-1:0]    D_IN_2,
    input  logic                     WE_2,
    input  logic [rd_name_width-1:0] RD_NAME_1,
    output logic [data_width-1:0]    D_OUT_1,
    output logic                     VALID_OUT_1,
    input  logic [rd_name_width-1:0] RD_NAME_2,
    output logic [data_width-1:0]    D_OUT_2,
    output logic                     VALID_OUT_2,
    input  logic [name_width-1:0]    W_F,
    input  logic                     WFE,
    output logic                     F_READY,
    input  logic                     FE_1,
    input  logic                     FE_2
);

    localparam int NUM_NAMES = 1 << name_width;
    localparam int RD_SLOTS  = 1 << rd_name_width;
    localparam logic [rd_name_width:0] FULL_COUNT = RD_SLOTS[rd_name_width:0];

    logic [data_width-1:0]    rf [lo_arch:hi_arch];

    logic [NUM_NAMES-1:0]     wq_valid;
    logic [NUM_NAMES-1:0]     wq_written;
    logic [addr_width-1:0]    wq_addr [NUM_NAMES];
    logic [name_width-1:0]    wq_head;
    logic [name_width-1:0]    wq_owner;

    logic [RD_SLOTS-1:0]      rs_in_use [2];
    logic [RD_SLOTS-1:0]      rs_valid  [2];
    logic [name_width-1:0]    rs_pend   [2][RD_SLOTS];
    logic [data_width-1:0]    rs_data   [2][RD_SLOTS];
    logic [rd_name_width-1:0] rs_head   [2];
    logic [rd_name_width-1:0] rs_tail   [2];
    logic [rd_name_width:0]   rs_count  [2];

    logic [addr_width-1:0]    rd_addr [2];
    logic [rd_name_width-1:0] rd_sel  [2];
    logic [1:0]               rd_rese;
    logic [1:0]               rd_fe;

    logic [1:0]               cf_found;
    logic [name_width-1:0]    cf_name [2];
    logic [name_width-1:0]    cf_age  [2];
    logic [name_width-1:0]    cand_age;
    logic [1:0]               cf_hit1;
    logic [1:0]               cf_hit2;
    logic [1:0]               res_valid;
    logic [data_width-1:0]    res_data [2];
    logic [1:0]               rres_ready;
    logic [1:0]               rd_alloc_ok;
    logic [1:0]               rd_free_ok;
    logic [1:0]               out_hit1;
    logic [1:0]               out_hit2;
    logic [1:0]               out_valid;
    logic [data_width-1:0]    out_data [2];

    assign rd_addr[0] = ADDR_1;
    assign rd_addr[1] = ADDR_2;
    assign rd_sel[0]  = RD_NAME_1;
    assign rd_sel[1]  = RD_NAME_2;
    assign rd_rese    = {RRESE_2, RRESE_1};
    assign rd_fe      = {FE_2, FE_1};

    assign ALLOC_READY  = !wq_valid[wq_head];
    assign NAME_OUT     = wq_head;
    assign F_READY      = (W_F == wq_owner);
    assign RRES_READY_1 = rres_ready[0];
    assign RRES_READY_2 = rres_ready[1];
    assign RNAME_OUT_1  = rs_tail[0];
    assign RNAME_OUT_2  = rs_tail[1];
    assign VALID_OUT_1  = out_valid[0];
    assign VALID_OUT_2  = out_valid[1];
    assign D_OUT_1      = out_data[0];
    assign D_OUT_2      = out_data[1];

    // Youngest matching write owner (largest distance from owner) decides where read data comes from
    always_comb begin
        cand_age = '0;
        for (int p = 0; p < 2; p++) begin
            cf_found[p] = 1'b0;
            cf_name[p]  = '0;
            cf_age[p]   = '0;
            for (int n = 0; n < NUM_NAMES; n++) begin
                cand_age = name_width'(n) - wq_owner;
                if (wq_valid[n] && (wq_addr[n] == rd_addr[p]) &&
                    (!cf_found[p] || (cand_age >= cf_age[p]))) begin
                    cf_found[p] = 1'b1;
                    cf_name[p]  = name_width'(n);
                    cf_age[p]   = cand_age;
                end
            end
            cf_hit1[p]     = cf_found[p] && WE_1 && (NAME_IN_1 == cf_name[p]);
            cf_hit2[p]     = cf_found[p] && WE_2 && (NAME_IN_2 == cf_name[p]);
            res_data[p]    = cf_hit1[p] ? D_IN_1 : (cf_hit2[p] ? D_IN_2 : rf[rd_addr[p]]);
            res_valid[p]   = !(cf_found[p] && !wq_written[cf_name[p]] && !(cf_hit1[p] || cf_hit2[p]));
            rres_ready[p]  = (rs_count[p] != FULL_COUNT) || rd_fe[p];
            rd_alloc_ok[p] = rd_rese[p] && rres_ready[p];
            rd_free_ok[p]  = rd_fe[p] && (rs_count[p] != '0);

            out_hit1[p]  = WE_1 && (NAME_IN_1 == rs_pend[p][rd_sel[p]]);
            out_hit2[p]  = WE_2 && (NAME_IN_2 == rs_pend[p][rd_sel[p]]);
            out_valid[p] = rs_in_use[p][rd_sel[p]] &&
                           (rs_valid[p][rd_sel[p]] || out_hit1[p] || out_hit2[p]);
            out_data[p]  = rs_data[p][rd_sel[p]];
            if (!rs_valid[p][rd_sel[p]] && (out_hit1[p] || out_hit2[p]))
                out_data[p] = out_hit1[p] ? D_IN_1 : D_IN_2;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wq_head    <= '0;
            wq_owner   <= '0;
            wq_valid   <= '0;
            wq_written <= '0;
        end else begin
            if (WE_2) wq_written[NAME_IN_2] <= 1'b1;
            if (WE_1) wq_written[NAME_IN_1] <= 1'b1;
            if (WFE && F_READY) begin
                wq_valid[W_F]   <= 1'b0;
                wq_written[W_F] <= 1'b0;
                wq_owner        <= wq_owner + 1'b1;
            end
            if (ALLOC_E && ALLOC_READY) begin
                wq_valid[wq_head]   <= 1'b1;
                wq_written[wq_head] <= 1'b0;
                wq_addr[wq_head]    <= ADDR_IN;
                wq_head             <= wq_head + 1'b1;
            end
        end
    end

    // Port 2 is written first so port 1 wins when both name the same entry
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (WE_2) rf[wq_addr[NAME_IN_2]] <= D_IN_2;
            if (WE_1) rf[wq_addr[NAME_IN_1]] <= D_IN_1;
        end
    end

    // Pending latch, then free, then alloc: a full queue freeing and allocating reuses the head slot
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int p = 0; p < 2; p++) begin
                rs_in_use[p] <= '0;
                rs_valid[p]  <= '0;
                rs_head[p]   <= '0;
                rs_tail[p]   <= '0;
                rs_count[p]  <= '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                for (int s = 0; s < RD_SLOTS; s++) begin
                    if (rs_in_use[p][s] && !rs_valid[p][s]) begin
                        if (WE_1 && (NAME_IN_1 == rs_pend[p][s])) begin
                            rs_data[p][s]  <= D_IN_1;
                            rs_valid[p][s] <= 1'b1;
                        end else if (WE_2 && (NAME_IN_2 == rs_pend[p][s])) begin
                            rs_data[p][s]  <= D_IN_2;
                            rs_valid[p][s] <= 1'b1;
                        end
                    end
                end
                if (rd_free_ok[p]) begin
                    rs_in_use[p][rs_head[p]] <= 1'b0;
                    rs_valid[p][rs_head[p]]  <= 1'b0;
                    rs_head[p]               <= rs_head[p] + 1'b1;
                end
                if (rd_alloc_ok[p]) begin
                    rs_in_use[p][rs_tail[p]] <= 1'b1;
                    rs_valid[p][rs_tail[p]]  <= res_valid[p];
                    rs_pend[p][rs_tail[p]]   <= cf_name[p];
                    rs_data[p][rs_tail[p]]   <= res_data[p];
                    rs_tail[p]               <= rs_tail[p] + 1'b1;
                end
                case ({rd_alloc_ok[p], rd_free_ok[p]})
                    2'b10:   rs_count[p] <= rs_count[p] + 1'b1;
                    2'b01:   rs_count[p] <= rs_count[p] - 1'b1;
                    default: rs_count[p] <= rs_count[p];
                endcase
            end
        end
    end

endmodule
